// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-position shift sequencer: shift-type
// encoding, FSM states and small decode helpers.
package shift_sequencer_pkg;

  typedef enum logic [2:0] {
    SHIFT_NONE = 3'b000,
    SHIFT_ROL  = 3'b001,
    SHIFT_ROR  = 3'b010,
    SHIFT_LSL  = 3'b011,
    SHIFT_ASR  = 3'b100,
    SHIFT_LSR  = 3'b101
  } shift_type_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  // 110/111 are reserved and behave as no shift.
  function automatic logic is_none(input logic [2:0] t);
    return !(t inside {SHIFT_ROL, SHIFT_ROR, SHIFT_LSL, SHIFT_ASR, SHIFT_LSR});
  endfunction

  function automatic logic carry_from_msb(input logic [2:0] t);
    return (t == SHIFT_ROL) || (t == SHIFT_LSL);
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the multicycle control FSM (master) and
// the shift sequencer (slave).
interface shift_sequencer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
);
  logic             start;
  logic [2:0]       shift_type;
  logic [AMT_W-1:0] shamt;
  logic [WIDTH-1:0] operand;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;
  logic             negative;

  modport master (
    output start, shift_type, shamt, operand,
    input  busy, done, result, carry_out, zero, negative
  );

  modport slave (
    input  start, shift_type, shamt, operand,
    output busy, done, result, carry_out, zero, negative
  );
endinterface

// File: rtl/shift_sequencer_step.sv
// Single-step shifter: one bit of rotate/shift per use, combinational.
module Shifter
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] In,
  input  logic [2:0]       ShiftType,
  output logic [WIDTH-1:0] Out
);

  always_comb begin
    Out = In;
    case (ShiftType)
      SHIFT_ROL: Out = {In[WIDTH-2:0], In[WIDTH-1]};
      SHIFT_ROR: Out = {In[0], In[WIDTH-1:1]};
      SHIFT_LSL: Out = {In[WIDTH-2:0], 1'b0};
      SHIFT_ASR: Out = {In[WIDTH-1], In[WIDTH-1:1]};
      SHIFT_LSR: Out = {1'b0, In[WIDTH-1:1]};
      default:   Out = In;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-position shift/rotate sequencer: latches a request and applies one
// single-bit step per clock, then reports result and flags with a done pulse.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  shift_sequencer_if.slave bus
);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [2:0]       typ_q;
  logic [AMT_W-1:0] cnt_q;
  logic [WIDTH-1:0] step_out;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;
  logic             neg_q;

  Shifter #(.WIDTH(WIDTH)) u_step (
    .In        (acc_q),
    .ShiftType (typ_q),
    .Out       (step_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      typ_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            acc_q <= bus.operand;
            typ_q <= bus.shift_type;
            cnt_q <= bus.shamt;
            // Zero-step requests bypass SHIFT so cnt never underflows.
            if (bus.shamt == '0 || is_none(bus.shift_type)) begin
              result_q <= bus.operand;
              carry_q  <= 1'b0;
              zero_q   <= (bus.operand == '0);
              neg_q    <= bus.operand[WIDTH-1];
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          acc_q   <= step_out;
          carry_q <= carry_from_msb(typ_q) ? acc_q[WIDTH-1] : acc_q[0];
          cnt_q   <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            result_q <= step_out;
            zero_q   <= (step_out == '0);
            neg_q    <= step_out[WIDTH-1];
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;

endmodule
